// File: rtl/wb_interconnect.sv
// Single-master, N-slave Wishbone classic interconnect: windowed address decode,
// latched slave selection, bus error on unmapped access or slave timeout.
module wb_interconnect #(
  parameter int                       N_SLAVES       = 4,
  parameter logic [N_SLAVES*32-1:0]   SLAVE_BASE     = {32'h100, 32'h80, 32'h40, 32'h0},
  parameter logic [N_SLAVES*32-1:0]   SLAVE_SIZE     = {32'h00100000, 32'h40, 32'h40, 32'h40},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_m_cyc,
  input  logic                    i_m_stb,
  input  logic                    i_m_we,
  input  logic [3:0]              i_m_sel,
  input  logic [31:0]             i_m_adr,
  input  logic [31:0]             i_m_dat,
  output logic [31:0]             o_m_dat,
  output logic                    o_m_ack,
  output logic                    o_m_err,
  output logic                    o_s_cyc,
  output logic [N_SLAVES-1:0]     o_s_stb,
  output logic                    o_s_we,
  output logic [3:0]              o_s_sel,
  output logic [31:0]             o_s_adr,
  output logic [31:0]             o_s_dat,
  input  logic [N_SLAVES-1:0]     i_s_ack,
  input  logic [N_SLAVES*32-1:0]  i_s_dat,
  output logic [31:0]             o_err_addr,
  output logic [7:0]              o_err_count
);

  localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  // The counter never passes TIMEOUT_CYCLES-1: ACTIVE is always left at that value.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] ERR    = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          req;
  logic          sel_ack;
  logic [31:0]   sel_dat;

  assign o_s_cyc = i_m_cyc;
  assign o_s_we  = i_m_we;
  assign o_s_sel = i_m_sel;
  assign o_s_adr = i_m_adr;
  assign o_s_dat = i_m_dat;

  assign req     = i_m_cyc & i_m_stb;
  assign sel_ack = i_s_ack[idx];
  assign sel_dat = i_s_dat[idx*32 +: 32];

  // Descending scan so the lowest matching index is the one left standing.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (SLAVE_SIZE[i*32 +: 32] != 32'h0 &&
          (i_m_adr - SLAVE_BASE[i*32 +: 32]) < SLAVE_SIZE[i*32 +: 32]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    o_s_stb = '0;
    if (state == ACTIVE) o_s_stb[idx] = req;
  end

  assign o_m_ack = (state == ACTIVE) & i_m_cyc & sel_ack;
  assign o_m_err = (state == ERR);
  assign o_m_dat = o_m_ack ? sel_dat : (o_m_err ? ERR_DATA : 32'h0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      o_err_addr  <= 32'h0;
      o_err_count <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              idx   <= hit_idx;
              cnt   <= '0;
              state <= ACTIVE;
            end else begin
              o_err_addr <= i_m_adr;
              state      <= ERR;
            end
          end
        end
        ACTIVE: begin
          // A master abort or an ack in the final cycle both take priority over timeout.
          if (!i_m_cyc || sel_ack) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            o_err_addr <= i_m_adr;
            state      <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR: begin
          if (o_err_count != 8'hFF) o_err_count <= o_err_count + 8'h1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_interconnect.md
Name: wb_interconnect

Overview:
- Parametrised single-master, N-slave Wishbone classic interconnect. It replaces the hand-written address decode and ack/data OR-mux in the SoC top.
- Decodes the master address against per-slave base/size windows and latches the slave selection for the whole transaction.
- Returns a bus error for unmapped addresses and for slaves that never ack (timeout).
- Captures the faulting address and counts errors for firmware diagnostics.

Parameters:
- N_SLAVES, 4, number of slave ports (1..16).
- SLAVE_BASE, {32'h100,32'h80,32'h40,32'h0}, packed N_SLAVES*32, slave i base at [i*32+:32].
- SLAVE_SIZE, {32'h00100000,32'h40,32'h40,32'h40}, packed N_SLAVES*32, window size in bytes; 0 disables the slave.
- TIMEOUT_CYCLES, 255, maximum cycles in ACTIVE before the error response; must be >=1.
- ERR_DATA, 32'hDEADBEEF, value driven on o_m_dat during an error response.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_m_cyc  in  1  master cycle
- i_m_stb  in  1  master strobe
- i_m_we  in  1  master write enable
- i_m_sel  in  4  master byte select
- i_m_adr  in  32  master address
- i_m_dat  in  32  master write data
- o_m_dat  out  32  read data to master
- o_m_ack  out  1  transfer acknowledge to master
- o_m_err  out  1  bus error to master
- o_s_cyc  out  1  broadcast cycle (= i_m_cyc)
- o_s_stb  out  N_SLAVES  one-hot strobe, bit i to slave i
- o_s_we  out  1  broadcast write enable
- o_s_sel  out  4  broadcast byte select
- o_s_adr  out  32  broadcast address
- o_s_dat  out  32  broadcast write data
- i_s_ack  in  N_SLAVES  slave acks
- i_s_dat  in  N_SLAVES*32  slave read data, slave i at [i*32+:32]
- o_err_addr  out  32  address of the most recent errored transfer
- o_err_count  out  8  saturating error counter

Behaviour:
- Reset (async, rst=1):
  - FSM=IDLE; o_s_stb=0, o_m_ack=0, o_m_err=0, o_m_dat=0.
  - o_err_addr=0, o_err_count=0, timeout counter=0, latched index=0.
- o_s_cyc, o_s_we, o_s_sel, o_s_adr and o_s_dat are combinational pass-throughs of the master signals.
- Decode: slave i hits when SLAVE_SIZE[i]!=0 and (i_m_adr-SLAVE_BASE[i]) < SLAVE_SIZE[i], using 32-bit unsigned arithmetic. This form has no overflow at the top of the address space. On overlapping windows the lowest index wins.
- FSM states: IDLE, ACTIVE, ERR.
- IDLE:
  - On i_m_cyc&i_m_stb with a hit: latch idx, clear counter, go ACTIVE.
  - On i_m_cyc&i_m_stb with a miss: latch i_m_adr into o_err_addr, go ERR.
  - Nothing is driven to slaves in IDLE. Decode latency is 1 cycle: slave stb asserts in the cycle after master stb.
- ACTIVE:
  - o_s_stb[idx] = i_m_stb&i_m_cyc; all other strobe bits are 0. The counter increments each cycle.
  - When i_s_ack[idx]=1: o_m_ack=1 combinationally in the same cycle, o_m_dat=i_s_dat[idx], next state IDLE.
  - i_s_ack bits of non-selected slaves are ignored.
  - When counter==TIMEOUT_CYCLES-1 and there is no ack: drop strobe, latch o_err_addr, go ERR. An ack in that same cycle wins; no error is raised.
  - When i_m_cyc falls: abort to IDLE with no ack, no err and no count.
- ERR:
  - o_m_err=1 and o_m_dat=ERR_DATA for exactly one cycle.
  - o_err_count increments, saturating at 255.
  - Next state is IDLE. o_m_ack is never asserted together with o_m_err.
- o_m_dat=0 whenever neither ack nor err is asserted.
- Master protocol: stb is held until ack/err and dropped the following cycle. A strobe still high in IDLE is treated as a new request.
- Throughput: at most one transfer per 2 cycles (IDLE+ACTIVE); an error costs 2 cycles (IDLE+ERR).
- Reset asserted mid-transaction returns to the reset state immediately; a pending slave ack is discarded.

Test Plan:
- Read 0x44: idx=1 latched, o_s_stb=4'b0010 one cycle after stb. Slave 1 acks with 0x12345678 → o_m_ack=1 with o_m_dat=0x12345678 the same cycle; o_s_stb=0 the next cycle.
- Write 0x00000104, sel=4'b0011, dat=0xA5A5 → o_s_stb=4'b1000, o_s_sel=4'b0011, o_s_dat=0xA5A5. Slave 3 acks → o_m_ack=1 the same cycle.
- Access 0x00200000 (unmapped) → o_m_err=1 and o_m_dat=0xDEADBEEF one cycle after stb; o_err_addr=0x00200000, o_err_count=1; no o_s_stb bit ever set.
- Timeout, TIMEOUT_CYCLES=4: slave 2 never acks → o_s_stb[2] high for 4 cycles then low, o_m_err pulse on the next cycle. Second case: slave acks in the 4th ACTIVE cycle → ack, no err.
- While idx=0 is active, slave 2 pulses ack → ignored, no o_m_ack. i_m_cyc dropped mid-transfer → FSM returns to IDLE, no ack/err, o_err_count unchanged.
- 260 unmapped accesses → o_err_count saturates at 255. Assert rst during ACTIVE → all outputs 0 the same cycle.
